// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types and helpers for the systolic array controller.
//   cmd_op_e      command opcode carried on cmd_op
//   ctrl_state_e  sequencer state encoding
//   run_last()    final value of the RUN phase counter for a given row count
package tpu_pkg;

  typedef enum logic {
    OP_LOAD_W  = 1'b0,
    OP_COMPUTE = 1'b1
  } cmd_op_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StSwap = 3'd2,
    StRun  = 3'd3,
    StDone = 3'd4
  } ctrl_state_e;

  // Last RUN counter value: rows of data reads, one cycle of read latency,
  // then 2N-3 cycles of skew and drain through the array.
  function automatic longint unsigned run_last(input longint unsigned rows,
                                               input int unsigned n);
    return rows + 64'(2 * n) - 64'd2;
  endfunction

endpackage

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: command sequencer for an N x N weight-stationary MAC array.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only while idle)
//   cmd_op                   0 = LOAD_W, 1 = COMPUTE
//   cmd_base                 weight (LOAD_W) or data (COMPUTE) base address
//   cmd_rows                 COMPUTE row count
//   wt_rd_en/wt_rd_addr      weight memory read port (1-cycle latency)
//   dat_rd_en/dat_rd_addr    data memory read port (1-cycle latency)
//   load_weight              shift weight row into the shadow registers
//   swap_weights             promote shadow weights to active
//   run                      advance the array
//   res_valid                deskewed result row valid
//   busy                     controller not idle
//   done                     single-cycle pulse at command completion
//
// Build option SYSTOLIC_CTRL_PERF_EN adds saturating 32-bit counters
// perf_busy_cycles and perf_run_cycles, cleared only by rst.
module systolic_ctrl
  import tpu_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned ROWS_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ROWS_W-1:0] cmd_rows,
  output logic              wt_rd_en,
  output logic [ADDR_W-1:0] wt_rd_addr,
  output logic              dat_rd_en,
  output logic [ADDR_W-1:0] dat_rd_addr,
  output logic              load_weight,
  output logic              swap_weights,
  output logic              run,
  output logic              res_valid,
  output logic              busy,
  output logic              done
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_busy_cycles,
  output logic [31:0]       perf_run_cycles
`endif
);

  // Wide enough that rows = 2^ROWS_W-1 plus the 2N-2 drain tail never wraps.
  localparam int unsigned CNT_W = ROWS_W + $clog2(2 * N) + 1;

  localparam logic [CNT_W-1:0]  NCnt     = CNT_W'(N);
  localparam logic [CNT_W-1:0]  NPlusOne = CNT_W'(N + 1);
  localparam logic [ADDR_W-1:0] TopRow   = ADDR_W'(N - 1);

  ctrl_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ROWS_W-1:0] rows_q, rows_d;
  logic              shadow_valid_q, shadow_valid_d;

  cmd_op_e           op;
  logic [CNT_W-1:0]  rows_ext;
  logic [CNT_W-1:0]  cnt_last;

  assign op       = cmd_op_e'(cmd_op);
  assign rows_ext = CNT_W'(rows_q);
  assign cnt_last = CNT_W'(run_last(64'(rows_q), N));

  // Next-state logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    base_d         = base_q;
    rows_d         = rows_q;
    shadow_valid_d = shadow_valid_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          base_d = cmd_base;
          rows_d = cmd_rows;
          cnt_d  = '0;
          if (op == OP_LOAD_W) begin
            state_d = StLoad;
          end else if (shadow_valid_q) begin
            state_d = StSwap;
          end else if (cmd_rows == '0) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end
      StLoad: begin
        if (cnt_q == NCnt) begin
          state_d        = StDone;
          cnt_d          = '0;
          shadow_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSwap: begin
        shadow_valid_d = 1'b0;
        cnt_d          = '0;
        state_d        = (rows_q == '0) ? StDone : StRun;
      end
      StRun: begin
        if (cnt_q == cnt_last) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      base_q         <= '0;
      rows_q         <= '0;
      shadow_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      base_q         <= base_d;
      rows_q         <= rows_d;
      shadow_valid_q <= shadow_valid_d;
    end
  end

  // Outputs are decoded from state and counter so an asynchronous reset
  // drops every strobe immediately.
  always_comb begin
    cmd_ready    = (state_q == StIdle);
    busy         = (state_q != StIdle);
    wt_rd_en     = 1'b0;
    wt_rd_addr   = '0;
    dat_rd_en    = 1'b0;
    dat_rd_addr  = '0;
    load_weight  = 1'b0;
    swap_weights = 1'b0;
    run          = 1'b0;
    res_valid    = 1'b0;
    done         = 1'b0;

    unique case (state_q)
      StLoad: begin
        // Rows fetched top-down so the first row loaded ends up deepest.
        if (cnt_q < NCnt) begin
          wt_rd_en   = 1'b1;
          wt_rd_addr = base_q + TopRow - ADDR_W'(cnt_q);
        end
        // Weight data arrives one cycle after the read strobe.
        load_weight = (cnt_q != '0);
      end
      StSwap: begin
        swap_weights = 1'b1;
      end
      StRun: begin
        if (cnt_q < rows_ext) begin
          dat_rd_en   = 1'b1;
          dat_rd_addr = base_q + ADDR_W'(cnt_q);
        end
        run       = (cnt_q != '0);
        res_valid = (cnt_q >= NPlusOne) && (cnt_q <= rows_ext + NCnt);
      end
      StDone: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] perf_busy_q, perf_run_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_q <= '0;
      perf_run_q  <= '0;
    end else begin
      if (busy && (perf_busy_q != '1)) begin
        perf_busy_q <= perf_busy_q + 32'd1;
      end
      if (run && (perf_run_q != '1)) begin
        perf_run_q <= perf_run_q + 32'd1;
      end
    end
  end

  assign perf_busy_cycles = perf_busy_q;
  assign perf_run_cycles  = perf_run_q;
`endif

endmodule
